// File: rtl/rf_multiport.sv
// rf_multiport: parametrised register file, one write port, two registered read ports, sync bulk clear
//   clk               rising-edge clock
//   reset             synchronous active-low reset
//   clr               synchronous clear of all words
//   we/waddr/wdata    write port
//   re_a/raddr_a      read port A request; rdata_a registered data
//   re_b/raddr_b      read port B request; rdata_b registered data
//   wr_ok             registered: previous cycle's write was accepted
module rf_multiport #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    parameter int ZERO_REG = 0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             wr_ok
);
    localparam logic [AW:0] DW = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wacc;
    logic             ok_a;
    logic             ok_b;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    // an address is readable if it exists and is not the hardwired zero word
    assign ok_a = ({1'b0, raddr_a} < DW) && !(ZERO_REG != 0 && raddr_a == '0);
    assign ok_b = ({1'b0, raddr_b} < DW) && !(ZERO_REG != 0 && raddr_b == '0);
    assign wacc = we && !clr && ({1'b0, waddr} < DW) && !(ZERO_REG != 0 && waddr == '0);
    // write-first: a same-cycle accepted write to the read address is forwarded
    assign rd_a = (clr || !ok_a) ? '0 : (wacc && raddr_a == waddr) ? wdata : mem[raddr_a];
    assign rd_b = (clr || !ok_b) ? '0 : (wacc && raddr_b == waddr) ? wdata : mem[raddr_b];
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wacc) begin
            mem[waddr] <= wdata;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_a <= '0;
            rdata_b <= '0;
            wr_ok   <= 1'b0;
        end else begin
            wr_ok <= wacc;
            if (re_a) rdata_a <= rd_a;
            if (re_b) rdata_b <= rd_b;
        end
    end
endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: checks a default rf_multiport and a ZERO_REG=1, WIDTH=8, DEPTH=6 one against a word-array model
module tb_rf_multiport;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic       we = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic       re_a = 1'b0;
    logic [2:0] raddr_a = '0;
    logic       re_b = 1'b0;
    logic [2:0] raddr_b = '0;
    logic [2:0] rdata_a0, rdata_b0;
    logic       wr_ok0;
    logic [7:0] rdata_a1, rdata_b1;
    logic       wr_ok1;
    logic [2:0] m0 [8];
    logic [7:0] m1 [8];
    logic [2:0] e0a, e0b;
    logic [7:0] e1a, e1b;
    logic       e0ok, e1ok;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_multiport dut0 (
        .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata[2:0]),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a0),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b0), .wr_ok(wr_ok0)
    );

    rf_multiport #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1)) dut1 (
        .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a1),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b1), .wr_ok(wr_ok1)
    );

    // Model: the write lands first, then reads see the updated array (write-first).
    // In the zero-register file, word 0 and the missing words 6,7 are simply never written.
    task automatic tick();
        logic acc1;
        @(posedge clk);
        acc1 = we && !clr && waddr < 6 && waddr != 0;
        if (!reset || clr) begin
            for (int i = 0; i < 8; i++) begin
                m0[i] = '0;
                m1[i] = '0;
            end
        end else begin
            if (we) m0[waddr] = wdata[2:0];
            if (acc1) m1[waddr] = wdata;
        end
        if (!reset) begin
            e0a = '0; e0b = '0; e1a = '0; e1b = '0; e0ok = 1'b0; e1ok = 1'b0;
        end else begin
            e0ok = we && !clr;
            e1ok = acc1;
            if (re_a) begin e0a = m0[raddr_a]; e1a = m1[raddr_a]; end
            if (re_b) begin e0b = m0[raddr_b]; e1b = m1[raddr_b]; end
        end
        #1;
    endtask

    task automatic idle();
        clr = 0; we = 0; re_a = 0; re_b = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        for (int i = 0; i < 8; i++) begin
            we = 1; waddr = 3'(i); wdata = 8'($urandom); re_a = 1; raddr_a = 3'(i); re_b = 1; raddr_b = 3'(7 - i);
            tick();
        end
        reset = 0;
        tick();
        if ({rdata_a0, rdata_b0, wr_ok0} !== 7'd0) begin errors++; $display("FAIL reset_out0 got=%h want=0", {rdata_a0, rdata_b0, wr_ok0}); end
        checks++;
        if ({rdata_a1, rdata_b1, wr_ok1} !== 17'd0) begin errors++; $display("FAIL reset_out1 got=%h want=0", {rdata_a1, rdata_b1, wr_ok1}); end
        checks++;
        reset = 1; idle();
        for (int i = 0; i < 8; i++) begin
            re_a = 1; raddr_a = 3'(i); re_b = 1; raddr_b = 3'(i);
            tick();
            if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== 22'd0) begin
                errors++; $display("FAIL reset_read addr=%0d got=%h want=0", i, {rdata_a0, rdata_b0, rdata_a1, rdata_b1});
            end
            checks++;
        end
        idle();
    endtask

    task automatic test_write_read();
        we = 1; waddr = 3; wdata = 8'h05;
        tick();
        if (wr_ok0 !== 1'b1 || wr_ok1 !== 1'b1) begin errors++; $display("FAIL wr_ok got=%b%b want=11", wr_ok0, wr_ok1); end
        checks++;
        idle(); re_a = 1; raddr_a = 3;
        tick();
        if (rdata_a0 !== 3'b101) begin errors++; $display("FAIL read0 got=%b want=101", rdata_a0); end
        checks++;
        if (rdata_a1 !== 8'h05) begin errors++; $display("FAIL read1 got=%h want=05", rdata_a1); end
        checks++;
        if (wr_ok0 !== 1'b0) begin errors++; $display("FAIL wr_ok_drop got=%b want=0", wr_ok0); end
        checks++;
        idle();
    endtask

    task automatic test_bypass();
        we = 1; waddr = 5; wdata = 8'h06; re_a = 1; re_b = 1; raddr_a = 5; raddr_b = 5;
        tick();
        if (rdata_a0 !== 3'b110 || rdata_b0 !== 3'b110) begin errors++; $display("FAIL bypass0 got=%b %b want=110", rdata_a0, rdata_b0); end
        checks++;
        if (rdata_a1 !== 8'h06 || rdata_b1 !== 8'h06) begin errors++; $display("FAIL bypass1 got=%h %h want=06", rdata_a1, rdata_b1); end
        checks++;
        idle();
    endtask

    task automatic test_hold();
        we = 1; waddr = 4; wdata = 8'h03;
        tick();
        idle(); re_b = 1; raddr_b = 4;
        tick();
        if (rdata_b0 !== 3'b011) begin errors++; $display("FAIL hold_setup got=%b want=011", rdata_b0); end
        checks++;
        idle(); we = 1; waddr = 4; wdata = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (rdata_b0 !== 3'b011 || rdata_b1 !== 8'h03) begin errors++; $display("FAIL hold cyc=%0d got=%b %h want=011 03", i, rdata_b0, rdata_b1); end
            checks++;
        end
        idle(); re_b = 1;
        tick();
        if (rdata_b0 !== 3'b000 || rdata_b1 !== 8'h00) begin errors++; $display("FAIL hold_release got=%b %h want=0", rdata_b0, rdata_b1); end
        checks++;
        idle();
    endtask

    task automatic test_clr();
        for (int i = 0; i < 8; i++) begin
            we = 1; waddr = 3'(i); wdata = 8'hFF;
            tick();
        end
        idle(); clr = 1; we = 1; waddr = 2; wdata = 8'h01; re_a = 1; raddr_a = 2; re_b = 1; raddr_b = 7;
        tick();
        if (wr_ok0 !== 1'b0 || wr_ok1 !== 1'b0) begin errors++; $display("FAIL clr_wr_ok got=%b%b want=00", wr_ok0, wr_ok1); end
        checks++;
        if ({rdata_a0, rdata_b0, rdata_a1} !== 14'd0) begin errors++; $display("FAIL clr_read got=%h want=0", {rdata_a0, rdata_b0, rdata_a1}); end
        checks++;
        idle();
        for (int i = 0; i < 8; i++) begin
            re_a = 1; raddr_a = 3'(i);
            tick();
            if (rdata_a0 !== 3'd0) begin errors++; $display("FAIL clr_word addr=%0d got=%b want=0", i, rdata_a0); end
            checks++;
        end
        idle(); reset = 0; we = 1; waddr = 1; wdata = 8'hFF;
        tick();
        reset = 1; idle(); re_a = 1; raddr_a = 1;
        tick();
        if (rdata_a0 !== 3'd0 || rdata_a1 !== 8'd0 || wr_ok0 !== 1'b0) begin
            errors++; $display("FAIL reset_blocks_write got=%b %h %b want=0 0 0", rdata_a0, rdata_a1, wr_ok0);
        end
        checks++;
        idle();
    endtask

    task automatic test_zero_reg();
        we = 1; waddr = 0; wdata = 8'hFF;
        tick();
        if (wr_ok1 !== 1'b0 || wr_ok0 !== 1'b1) begin errors++; $display("FAIL zero_wr_ok got=%b%b want=0 1", wr_ok1, wr_ok0); end
        checks++;
        idle(); re_a = 1; raddr_a = 0;
        tick();
        if (rdata_a1 !== 8'h00 || rdata_a0 !== 3'b111) begin errors++; $display("FAIL zero_read got=%h %b want=00 111", rdata_a1, rdata_a0); end
        checks++;
        idle(); we = 1; waddr = 7; wdata = 8'hA5;
        tick();
        if (wr_ok1 !== 1'b0) begin errors++; $display("FAIL oob_wr_ok got=%b want=0", wr_ok1); end
        checks++;
        idle(); re_a = 1; raddr_a = 7; re_b = 1; raddr_b = 6;
        tick();
        if (rdata_a1 !== 8'h00 || rdata_b1 !== 8'h00) begin errors++; $display("FAIL oob_read got=%h %h want=00", rdata_a1, rdata_b1); end
        checks++;
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) != 0);
            clr = ($urandom_range(0, 24) == 0);
            we = 1'($urandom); waddr = 3'($urandom); wdata = 8'($urandom);
            re_a = 1'($urandom); raddr_a = 3'($urandom);
            re_b = 1'($urandom); raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom);
            tick();
            if (rdata_a0 !== e0a || rdata_b0 !== e0b || wr_ok0 !== e0ok) begin
                errors++; $display("FAIL rand0 n=%0d got=%b %b %b want=%b %b %b", n, rdata_a0, rdata_b0, wr_ok0, e0a, e0b, e0ok);
            end
            checks++;
            if (rdata_a1 !== e1a || rdata_b1 !== e1b || wr_ok1 !== e1ok) begin
                errors++; $display("FAIL rand1 n=%0d got=%h %h %b want=%h %h %b", n, rdata_a1, rdata_b1, wr_ok1, e1a, e1b, e1ok);
            end
            checks++;
        end
        reset = 1; idle();
    endtask

    initial begin
        #1;
        tick();
        test_reset();
        test_write_read();
        test_bypass();
        test_hold();
        test_clr();
        test_zero_reg();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
